// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, grant encoding and 4/4/4 colour layout for the frame-buffer path
//   DEF_ADDR_W / DEF_DATA_W : default address and pixel widths (160x120 x 12-bit)
//   gnt_t                   : frame-buffer port owner for one cycle
//   *_LSB / CHAN_W          : colour field offsets inside a pixel word
package vga_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 12;
    localparam int CHAN_W = 4;
    localparam int RED_LSB = 8;
    localparam int GRN_LSB = 4;
    localparam int BLU_LSB = 0;
    typedef enum logic [1:0] {GNT_IDLE, GNT_READ, GNT_WRITE} gnt_t;
    function automatic logic [DEF_DATA_W-1:0] rgb(input logic [CHAN_W-1:0] r, input logic [CHAN_W-1:0] g,
                                                   input logic [CHAN_W-1:0] b);
        return {r, g, b};
    endfunction
endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous write FIFO holding {addr, data} pairs for the frame buffer
//   push/din  : enqueue (ignored when full)
//   pop/head  : dequeue / current oldest entry (pop ignored when empty)
//   count     : occupancy, 0..DEPTH
//   full/empty: decoded from count
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head = mem[rptr];
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port frame buffer between scan-out reads and buffered pixel writes
//   rd_req/rd_addr -> rd_valid/rd_data : scan-out reads, absolute priority, one-cycle latency
//   wr_valid/wr_addr/wr_data/wr_ready : writer handshake into the write FIFO
//   mem_*                             : frame-buffer RAM port (synchronous read data on mem_rdata)
//   starve/starve_clr                 : sticky flag for writes blocked STARVE_LIMIT cycles in a row
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              starve,
    input  logic              starve_clr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(STARVE_LIMIT + 1);
    gnt_t gnt, last_gnt;
    logic ready_q, full, empty, blocked, starve_set;
    logic [CW-1:0] count;
    logic [BW-1:0] blk_cnt;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    // Reads always win; the FIFO only gets the port when scan-out is idle.
    always_comb gnt = rst ? GNT_IDLE : rd_req ? GNT_READ : empty ? GNT_IDLE : GNT_WRITE;
    assign mem_en = gnt != GNT_IDLE;
    assign mem_we = gnt == GNT_WRITE;
    assign mem_addr = rd_req ? rd_addr : head_addr;
    assign mem_wdata = head_data;
    assign rd_valid = last_gnt == GNT_READ;
    assign rd_data = mem_rdata;
    // ready_q keeps wr_ready low during reset; full comes from the registered count.
    assign wr_ready = ready_q && !full;
    assign blocked = rd_req && count != '0;
    assign starve_set = blocked && blk_cnt >= BW'(STARVE_LIMIT - 1);
    fb_wr_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(ADDR_W + DATA_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (wr_valid && wr_ready),
        .din  ({wr_addr, wr_data}),
        .pop  (mem_we),
        .head ({head_addr, head_data}),
        .count(count),
        .full (full),
        .empty(empty)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            last_gnt <= GNT_IDLE;
            ready_q <= 1'b0;
            blk_cnt <= '0;
            starve <= 1'b0;
        end else begin
            last_gnt <= gnt;
            ready_q <= 1'b1;
            blk_cnt <= !blocked ? '0 : blk_cnt == BW'(STARVE_LIMIT) ? blk_cnt : blk_cnt + BW'(1);
            starve <= starve_set || (starve && !starve_clr);
        end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: table-driven and scoreboard bench for vga_fb_arbiter with a behavioural RAM
module tb_vga_fb_arbiter;
    localparam int AW = 15, DW = 12, DEPTH = 4, LIMIT = 8;
    logic clk = 1'b0, rst, rd_req, rd_valid, wr_valid, wr_ready, mem_en, mem_we, starve, starve_clr;
    logic [AW-1:0] rd_addr, wr_addr, mem_addr;
    logic [DW-1:0] rd_data, wr_data, mem_wdata, mem_rdata;
    int passed = 0, total = 0;
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] shadow [2**AW];
    logic [AW+DW-1:0] wq[$];
    logic [DW-1:0] rq[$];
    logic [AW+DW-1:0] mw;
    logic [DW-1:0] md;

    typedef struct {
        logic rd; logic [AW-1:0] ra; logic wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
        logic en; logic we; logic rdy;
    } vec_t;
    vec_t tv[10];
    logic [DW-1:0] pix [3];

    always #5 clk = ~clk;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .starve(starve), .starve_clr(starve_clr)
    );

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: sampled one time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (rst) begin
            wq.delete();
            rq.delete();
        end else begin
            chk("we_without_en", {31'b0, mem_we & ~mem_en}, 0);
            chk("rd_valid", {31'b0, rd_valid}, {31'b0, rq.size() != 0});
            if (rq.size() != 0) begin
                md = rq.pop_front();
                if (rd_valid) chk("rd_data", {20'b0, rd_data}, {20'b0, md});
            end
            if (wq.size() == 0) chk("no_write", {31'b0, mem_we}, 0);
            else if (mem_we) begin
                mw = wq.pop_front();
                chk("wr_addr_order", {17'b0, mem_addr}, {17'b0, mw[AW+DW-1:DW]});
                chk("wr_data_order", {20'b0, mem_wdata}, {20'b0, mw[DW-1:0]});
                shadow[mw[AW+DW-1:DW]] = mw[DW-1:0];
            end
            if (wr_valid && wr_ready) wq.push_back({wr_addr, wr_data});
            if (rd_req) rq.push_back(shadow[rd_addr]);
        end
    end

    task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd);
        @(negedge clk);
        rd_req = rd; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
        #2;
    endtask

    initial begin
        tv[0] = '{1'b1, 15'h010, 1'b1, 15'h100, 12'hA01, 1'b1, 1'b0, 1'b1};
        tv[1] = '{1'b1, 15'h011, 1'b1, 15'h101, 12'hA02, 1'b1, 1'b0, 1'b1};
        tv[2] = '{1'b1, 15'h012, 1'b1, 15'h102, 12'hA03, 1'b1, 1'b0, 1'b1};
        tv[3] = '{1'b1, 15'h013, 1'b1, 15'h103, 12'hA04, 1'b1, 1'b0, 1'b1};
        tv[4] = '{1'b1, 15'h014, 1'b1, 15'h104, 12'hA05, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 15'h000, 1'b0, 15'h000, 12'h000, 1'b1, 1'b1, 1'b0};
        tv[6] = '{1'b0, 15'h000, 1'b0, 15'h000, 12'h000, 1'b1, 1'b1, 1'b1};
        tv[7] = '{1'b0, 15'h000, 1'b0, 15'h000, 12'h000, 1'b1, 1'b1, 1'b1};
        tv[8] = '{1'b0, 15'h000, 1'b0, 15'h000, 12'h000, 1'b1, 1'b1, 1'b1};
        tv[9] = '{1'b0, 15'h000, 1'b0, 15'h000, 12'h000, 1'b0, 1'b0, 1'b1};
        pix = '{12'hF00, 12'h0F0, 12'h00F};
        for (int i = 0; i < 2**AW; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            ram[16+i] = pix[i];
            shadow[16+i] = pix[i];
        end
        ram[19] = 12'h123; shadow[19] = 12'h123;
        ram[20] = 12'h456; shadow[20] = 12'h456;
        // Reset with a read request and a write offer pending.
        rst = 1'b1; starve_clr = 1'b0;
        rd_req = 1'b1; rd_addr = 15'h010; wr_valid = 1'b1; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 0);
        chk("rst_starve", {31'b0, starve}, 0);
        @(negedge clk);
        rst = 1'b0; rd_req = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        #2 chk("wr_ready_after_rst", {31'b0, wr_ready}, 1);
        // Read pipeline: one pixel per cycle, one cycle of latency.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 15'(16 + i), 1'b0, '0, '0);
            if (i > 0) chk($sformatf("rd_pipe_%0d", i - 1), {20'b0, rd_data}, {20'b0, pix[i-1]});
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("rd_pipe_2", {20'b0, rd_data}, {20'b0, pix[2]});
        chk("rd_pipe_valid", {31'b0, rd_valid}, 1);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("rd_pipe_end", {31'b0, rd_valid}, 0);
        // Blocked writes behind continuous reads, then drain.
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].rd, tv[i].ra, tv[i].wv, tv[i].wa, tv[i].wd);
            chk($sformatf("vec%0d_mem_en", i), {31'b0, mem_en}, {31'b0, tv[i].en});
            chk($sformatf("vec%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tv[i].we});
            chk($sformatf("vec%0d_wr_ready", i), {31'b0, wr_ready}, {31'b0, tv[i].rdy});
        end
        chk("vec_no_starve", {31'b0, starve}, 0);
        // Push and pop in the same cycle with two entries queued.
        drive(1'b1, 15'h010, 1'b1, 15'h200, 12'hB01);
        drive(1'b1, 15'h011, 1'b1, 15'h201, 12'hB02);
        drive(1'b0, '0, 1'b1, 15'h202, 12'hB03);
        chk("sim_pop_we", {31'b0, mem_we}, 1);
        chk("sim_pop_addr", {17'b0, mem_addr}, 32'h200);
        chk("sim_push_ready", {31'b0, wr_ready}, 1);
        drive(1'b1, 15'h011, 1'b0, '0, '0);
        chk("sim_count", {28'b0, dut.u_fifo.count}, 2);
        chk("sim_read_wins_we", {31'b0, mem_we}, 0);
        chk("sim_read_wins_addr", {17'b0, mem_addr}, 32'h011);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("sim_drain1", {17'b0, mem_addr}, 32'h201);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("sim_drain2", {17'b0, mem_addr}, 32'h202);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("sim_idle", {31'b0, mem_en}, 0);
        // Starvation: one entry pending under eight consecutive reads.
        drive(1'b1, 15'h012, 1'b1, 15'h300, 12'hC01);
        for (int i = 1; i <= LIMIT; i++) begin
            drive(1'b1, 15'h012, 1'b0, '0, '0);
            chk($sformatf("starve_pre_%0d", i), {31'b0, starve}, 0);
        end
        drive(1'b1, 15'h012, 1'b0, '0, '0);
        chk("starve_set", {31'b0, starve}, 1);
        starve_clr = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        starve_clr = 1'b0;
        chk("starve_set_wins", {31'b0, starve}, 1);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("starve_sticky", {31'b0, starve}, 1);
        starve_clr = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);
        starve_clr = 1'b0;
        chk("starve_cleared", {31'b0, starve}, 0);
        // Reset mid-drain with a read in flight.
        drive(1'b1, 15'h013, 1'b1, 15'h400, 12'hD01);
        drive(1'b1, 15'h013, 1'b1, 15'h401, 12'hD02);
        drive(1'b1, 15'h013, 1'b1, 15'h402, 12'hD03);
        drive(1'b0, '0, 1'b0, '0, '0);
        drive(1'b1, 15'h014, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b1; rd_req = 1'b0;
        #2;
        chk("mid_rst_mem_en", {31'b0, mem_en}, 0);
        chk("mid_rst_rd_valid", {31'b0, rd_valid}, 0);
        chk("mid_rst_wr_ready", {31'b0, wr_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b0, '0, '0);
            chk($sformatf("post_rst_no_we_%0d", i), {31'b0, mem_we}, 0);
        end
        chk("post_rst_count", {28'b0, dut.u_fifo.count}, 0);
        @(negedge clk);
        #6;
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
